// File: rtl/cnn_pkg.sv
// Shared constants and loader state encoding for the CNN front end.
// Latency: n/a (package only). Backpressure: n/a.
package cnn_pkg;
    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int IDX_W      = 10;
    localparam int IMG_BITS   = IMG_PIXELS * PIX_W;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;
endpackage

// File: rtl/frame_index_counter.sv
// Frame slot index: counts accepted pixels, wraps to 0 on terminal count, synchronous clear.
// Latency: index updates on the edge of the increment; tc_o is combinational from the index.
// Backpressure: none, increments only when told to.
module frame_index_counter
    import cnn_pkg::*;
#(
    parameter int COUNT = IMG_PIXELS,
    parameter int W     = IDX_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] idx_o,
    output logic         tc_o
);
    logic [W-1:0] idx_q, idx_d;

    assign tc_o  = (idx_q == W'(COUNT - 1));
    assign idx_o = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = tc_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/image_stream_loader.sv
// Assembles a 28x28 pixel stream into a frame buffer, pulses cnn_start, holds until cnn_done (s_last check: LOADER_LAST_CHECK_EN).
// Latency: accepted pixel visible in image_out one edge later; image_valid/cnn_start on the edge of the last accept.
// Backpressure: s_ready is registered from state only; deasserted for the whole HOLD phase.
module image_stream_loader
    import cnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    s_pixel,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [IMG_BITS-1:0] image_out,
    output logic                image_valid,
    output logic                cnn_start,
    input  logic                cnn_done,
    output logic                frame_err
);
    loader_state_e       state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                cnn_start_q, cnn_start_d;
    logic                frame_err_q, frame_err_d;
    logic [IMG_BITS-1:0] image_q;
    logic [IDX_W-1:0]    idx;
    logic                tc;
    logic                accept;
    logic                err;
    logic                frame_done;

    assign accept = s_valid && s_ready_q;

`ifdef LOADER_LAST_CHECK_EN
    // s_last must coincide exactly with the terminal slot, otherwise the frame is dropped
    assign err = accept && (s_last != tc);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign err = 1'b0;
`endif

    assign frame_done = accept && tc && !err;

    frame_index_counter #(
        .COUNT (IMG_PIXELS),
        .W     (IDX_W)
    ) u_idx (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (accept),
        .clr_i  (err),
        .idx_o  (idx),
        .tc_o   (tc)
    );

    always_comb begin
        state_d     = state_q;
        cnn_start_d = frame_done;
        frame_err_d = err;
        case (state_q)
            FILL:    if (frame_done) state_d = HOLD;
            HOLD:    if (cnn_done)   state_d = FILL;
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            s_ready_q   <= 1'b0;
            cnn_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            image_q     <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            cnn_start_q <= cnn_start_d;
            frame_err_q <= frame_err_d;
            if (accept) begin
                image_q[idx*PIX_W +: PIX_W] <= s_pixel;
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign image_out   = image_q;
    assign image_valid = (state_q == HOLD);
    assign cnn_start   = cnn_start_q;
    assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_image_stream_loader.sv
// Self-checking bench for image_stream_loader: table-driven frame loads plus hand-written corner sequences.
module tb_image_stream_loader;
    import cnn_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [PIX_W-1:0]    s_pixel = '0;
    logic                s_valid = 1'b0;
    logic                s_last = 1'b0;
    logic                s_ready;
    logic [IMG_BITS-1:0] image_out;
    logic                image_valid;
    logic                cnn_start;
    logic                cnn_done = 1'b0;
    logic                frame_err;

    always #5 clk = ~clk;

    image_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .s_pixel     (s_pixel),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .image_out   (image_out),
        .image_valid (image_valid),
        .cnn_start   (cnn_start),
        .cnn_done    (cnn_done),
        .frame_err   (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int start_cnt = 0;
    int err_cnt  = 0;

    // reference frame: pixel k of the stream belongs in slot k
    logic [7:0] frame_px [IMG_PIXELS];

    typedef struct {
        int         mode;
        int         gap_pct;
        int         probe_idx;
        logic [7:0] probe_exp;
    } vec_t;
    vec_t vecs [4];

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        #2;
        if (cnn_start) start_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < IMG_PIXELS; k++) begin
            if (bad < 0 && image_out[k*PIX_W +: PIX_W] !== frame_px[k]) bad = k;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: pixel %0d got %0h expected %0h", name, bad,
                     image_out[bad*PIX_W +: PIX_W], frame_px[bad]);
        end
    endtask

    task automatic gen_frame(input int mode);
        for (int k = 0; k < IMG_PIXELS; k++) begin
            case (mode)
                0:       frame_px[k] = 8'(k);
                1:       frame_px[k] = ~8'(k);
                2:       frame_px[k] = 8'(k * 3);
                default: frame_px[k] = 8'($urandom);
            endcase
        end
    endtask

    task automatic stream(input int n, input int gap_pct, input int last_at);
        bit rdy;
        int guard;
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_pixel = frame_px[k];
            s_last  = (k == last_at) || (k == IMG_PIXELS - 1);
            guard   = 0;
            do begin
                rdy = s_ready;
                tick();
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) begin
                ok = 1'b0;
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("stream_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic hold_and_release(input string tag);
        bit rdy_seen;
        rdy_seen = 1'b0;
        s_valid  = 1'b1;
        s_pixel  = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            if (s_ready) rdy_seen = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check({tag, "_hold_ready"}, 32'(rdy_seen), 32'd0);
        check({tag, "_hold_valid"}, 32'(image_valid), 32'd1);
        check_frame({tag, "_hold_frame"});
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        check({tag, "_rel_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_rel_valid"}, 32'(image_valid), 32'd0);
    endtask

    initial begin
        int s0, e0, t0, t1;

        vecs[0] = '{mode: 0, gap_pct: 0,  probe_idx: 783, probe_exp: 8'h0F};
        vecs[1] = '{mode: 0, gap_pct: 50, probe_idx: 0,   probe_exp: 8'h00};
        vecs[2] = '{mode: 1, gap_pct: 30, probe_idx: 1,   probe_exp: 8'hFE};
        vecs[3] = '{mode: 2, gap_pct: 50, probe_idx: 100, probe_exp: 8'h2C};

        // reset state
        tick();
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_valid", 32'(image_valid), 32'd0);
        check("rst_start", 32'(cnn_start), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_img_zero", 32'(|image_out), 32'd0);
        rst = 1'b1;
        check("rel_ready_before_edge", 32'(s_ready), 32'd0);
        tick();
        check("rel_ready_after_edge", 32'(s_ready), 32'd1);

        for (int v = 0; v < 4; v++) begin
            gen_frame(vecs[v].mode);
            s0 = start_cnt;
            stream(IMG_PIXELS, vecs[v].gap_pct, -1);
            check("load_valid", 32'(image_valid), 32'd1);
            check("load_start", 32'(cnn_start), 32'd1);
            check("load_ready_low", 32'(s_ready), 32'd0);
            check_frame("load_frame");
            check("load_probe", 32'(image_out[vecs[v].probe_idx*PIX_W +: PIX_W]), 32'(vecs[v].probe_exp));
            tick();
            check("start_clears", 32'(cnn_start), 32'd0);
            check("start_once", 32'(start_cnt - s0), 32'd1);
            hold_and_release("vec");
        end

        // reset mid-frame discards the partial frame
        gen_frame(3);
        stream(400, 0, -1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        check("mid_rst_img_zero", 32'(|image_out), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        gen_frame(2);
        stream(IMG_PIXELS, 20, -1);
        check("after_rst_valid", 32'(image_valid), 32'd1);
        check_frame("after_rst_frame");
        // reset in HOLD drops image_valid without waiting for an edge
        rst = 1'b0;
        #1;
        check("hold_rst_valid", 32'(image_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // early s_last on pixel 500
        e0 = err_cnt;
`ifdef LOADER_LAST_CHECK_EN
        gen_frame(3);
        stream(501, 0, 500);
        tick();
        check("early_last_err", 32'(err_cnt - e0), 32'd1);
        check("early_last_no_valid", 32'(image_valid), 32'd0);
        gen_frame(1);
        stream(IMG_PIXELS, 0, -1);
        check("after_err_valid", 32'(image_valid), 32'd1);
        check_frame("after_err_frame");
`else
        gen_frame(3);
        stream(IMG_PIXELS, 0, 500);
        check("count_frame_valid", 32'(image_valid), 32'd1);
        check_frame("count_frame");
        check("no_frame_err", 32'(err_cnt - e0), 32'd0);
`endif
        hold_and_release("last");

        // back-to-back frames, cnn_done one cycle after cnn_start
        gen_frame(0);
        stream(IMG_PIXELS, 0, -1);
        t0 = edge_cnt;
        check("b2b_first_valid", 32'(image_valid), 32'd1);
        tick();
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        gen_frame(2);
        stream(IMG_PIXELS, 0, -1);
        t1 = edge_cnt;
        check("b2b_second_valid", 32'(image_valid), 32'd1);
        check("b2b_period", 32'(t1 - t0), 32'd786);
        check_frame("b2b_frame");
        hold_and_release("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
